// File: rtl/ws2812_pkg.sv
// Shared WS2812 definitions: receiver state encoding and word geometry.
package ws2812_pkg;
  localparam int WORD_BITS = 24;

  typedef enum logic [1:0] {
    SYNC    = 2'd0,
    CAPTURE = 2'd1,
    FORWARD = 2'd2
  } rx_state_e;
endpackage

// File: rtl/ws2812_sync2.sv
// Two-flop synchronizer bringing the asynchronous WS2812 line into the clock domain.
module ws2812_sync2 (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);
  logic meta_q, sync_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;
endmodule

// File: rtl/ws2812_rx.sv
// WS2812 receiver: decodes the first 24-bit word of each frame, forwards the rest.
module ws2812_rx
  import ws2812_pkg::*;
#(
  parameter int THRESH_CYCLES   = 6,
  parameter int RESET_CYCLES    = 500,
  parameter int MAX_HIGH_CYCLES = 12
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  input  logic                 din,
  output logic                 dout,
  output logic [WORD_BITS-1:0] rgb_data,
  output logic                 rgb_valid,
  input  logic                 rgb_ready,
  output logic                 latch,
  output logic                 frame_err,
  output logic                 overrun
);
  // High counter saturates one past the limit so an over-long pulse is observable.
  localparam int HW = $clog2(MAX_HIGH_CYCLES + 2);
  localparam int LW = $clog2(RESET_CYCLES + 1);
  localparam logic [HW-1:0] HIGH_LIM = HW'(MAX_HIGH_CYCLES + 1);
  localparam logic [LW-1:0] LOW_LIM  = LW'(RESET_CYCLES);

  rx_state_e            state_q;
  logic                 din_s, din_s_q;
  logic [HW-1:0]        high_q, high_d;
  logic [LW-1:0]        low_q, low_d;
  logic [4:0]           bit_cnt_q;
  logic [WORD_BITS-1:0] shift_q, word_nxt, rgb_data_q;
  logic                 rgb_valid_q, latch_q, ferr_q, overrun_q, dout_q;
  logic                 fall, bit_val, too_long, gap, word_done;

  ws2812_sync2 u_sync (
    .clk_i (wb_clk_i),
    .rst_i (wb_rst_i),
    .d_i   (din),
    .q_o   (din_s)
  );

  assign fall      = din_s_q & ~din_s;
  assign bit_val   = (high_q >= HW'(THRESH_CYCLES));
  assign too_long  = din_s && (high_q == HW'(MAX_HIGH_CYCLES));
  assign gap       = !din_s && (low_q == LW'(RESET_CYCLES - 1));
  assign high_d    = !din_s ? '0 : (high_q == HIGH_LIM) ? high_q : high_q + 1'b1;
  assign low_d     = din_s ? '0 : (low_q == LOW_LIM) ? low_q : low_q + 1'b1;
  assign word_nxt  = {shift_q[WORD_BITS-2:0], bit_val};
  assign word_done = (state_q == CAPTURE) && fall && (bit_cnt_q == 5'(WORD_BITS - 1));

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q     <= SYNC;
      din_s_q     <= 1'b0;
      high_q      <= '0;
      low_q       <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      rgb_data_q  <= '0;
      rgb_valid_q <= 1'b0;
      latch_q     <= 1'b0;
      ferr_q      <= 1'b0;
      overrun_q   <= 1'b0;
      dout_q      <= 1'b0;
    end else begin
      din_s_q <= din_s;
      high_q  <= high_d;
      low_q   <= low_d;
      latch_q <= 1'b0;
      ferr_q  <= 1'b0;
      dout_q  <= (state_q == FORWARD) && din_s;

      case (state_q)
        SYNC: begin
          if (gap) begin
            state_q   <= CAPTURE;
            bit_cnt_q <= '0;
          end
        end
        CAPTURE: begin
          if (too_long) begin
            ferr_q    <= 1'b1;
            bit_cnt_q <= '0;
            state_q   <= SYNC;
          end else if (fall) begin
            shift_q <= word_nxt;
            if (word_done) begin
              bit_cnt_q <= 5'(WORD_BITS);
              state_q   <= FORWARD;
            end else begin
              bit_cnt_q <= bit_cnt_q + 1'b1;
            end
          end else if (gap) begin
            // A gap after a partial word is malformed; an empty frame is benign.
            if (bit_cnt_q != '0) ferr_q <= 1'b1;
            bit_cnt_q <= '0;
          end
        end
        FORWARD: begin
          if (too_long) begin
            ferr_q    <= 1'b1;
            bit_cnt_q <= '0;
            state_q   <= SYNC;
          end else if (gap) begin
            latch_q   <= 1'b1;
            bit_cnt_q <= '0;
            state_q   <= CAPTURE;
          end
        end
        default: state_q <= SYNC;
      endcase

      // Output slot: a word arriving while the old one is still unread is lost.
      if (word_done) begin
        if (!rgb_valid_q || rgb_ready) begin
          rgb_data_q  <= word_nxt;
          rgb_valid_q <= 1'b1;
        end else begin
          overrun_q <= 1'b1;
        end
      end else if (rgb_valid_q && rgb_ready) begin
        rgb_valid_q <= 1'b0;
      end
    end
  end

  assign dout      = dout_q;
  assign rgb_data  = rgb_data_q;
  assign rgb_valid = rgb_valid_q;
  assign latch     = latch_q;
  assign frame_err = ferr_q;
  assign overrun   = overrun_q;
endmodule

// File: tb/tb_ws2812_rx.sv
// Directed bench for ws2812_rx: decode, forwarding, framing errors, backpressure, reset.
module tb_ws2812_rx;
  import ws2812_pkg::*;

  logic        clk = 1'b0, rst = 1'b1, din = 1'b0, rdy = 1'b0;
  logic        dout, rgb_valid, latch, frame_err, overrun;
  logic [23:0] rgb_data;

  int n_cmp = 0, n_bad = 0;
  int n_latch = 0, n_ferr = 0, n_xfer = 0, n_dhi = 0;
  int b_latch, b_ferr, b_xfer, b_dhi;
  logic [2:0] hist = 3'b000;
  bit dchk = 1'b0;

  ws2812_rx dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst),
    .din       (din),
    .dout      (dout),
    .rgb_data  (rgb_data),
    .rgb_valid (rgb_valid),
    .rgb_ready (rdy),
    .latch     (latch),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    hist <= {hist[1:0], din};
    if (latch)              n_latch <= n_latch + 1;
    if (frame_err)          n_ferr  <= n_ferr + 1;
    if (rgb_valid && rdy)   n_xfer  <= n_xfer + 1;
    if (dout)               n_dhi   <= n_dhi + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Drive din for n cycles; optionally check dout against din three cycles earlier.
  task automatic hold(input logic v, input int n);
    din = v;
    repeat (n) begin
      @(posedge clk);
      #1;
      if (dchk) chk("dout_delay3", 32'(dout), 32'(hist[2]));
    end
  endtask

  task automatic send_bit(input logic b);
    hold(1'b1, b ? 7 : 3);
    hold(1'b0, b ? 5 : 9);
  endtask

  task automatic send_bits(input logic [23:0] w, input int n);
    for (int i = 23; i > 23 - n; i--) send_bit(w[i]);
  endtask

  task automatic snap();
    b_latch = n_latch; b_ferr = n_ferr; b_xfer = n_xfer; b_dhi = n_dhi;
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_data"},  32'(rgb_data),  32'h0);
    chk({tag, "_valid"}, 32'(rgb_valid), 32'h0);
    chk({tag, "_dout"},  32'(dout),      32'h0);
    chk({tag, "_latch"}, 32'(latch),     32'h0);
    chk({tag, "_ferr"},  32'(frame_err), 32'h0);
    chk({tag, "_ovr"},   32'(overrun),   32'h0);
  endtask

  initial begin
    // Reset state
    rst = 1'b1;
    hold(1'b0, 3);
    chk_reset_outs("rst");
    chk("rst_state", 32'(dut.state_q), 32'(SYNC));
    rst = 1'b0;

    // Initial sync gap, then one word 0xFF0000 and a latch gap
    snap();
    hold(1'b0, 505);
    chk("sync_no_latch", 32'(n_latch - b_latch), 0);
    send_bits(24'hFF0000, 24);
    hold(1'b0, 510);
    chk("w1_data",  32'(rgb_data),          32'hFF0000);
    chk("w1_valid", 32'(rgb_valid),         1);
    chk("w1_latch", 32'(n_latch - b_latch), 1);
    chk("w1_dout0", 32'(n_dhi - b_dhi),     0);
    chk("w1_ferr",  32'(n_ferr - b_ferr),   0);
    rdy = 1'b1;
    hold(1'b0, 1);
    chk("w1_consumed", 32'(rgb_valid), 0);

    // Two words in one frame: first decoded, second forwarded
    snap();
    send_bits(24'h123456, 24);
    dchk = 1'b1;
    send_bits(24'hABCDEF, 24);
    hold(1'b0, 4);
    dchk = 1'b0;
    chk("w2_fwd_seen", 32'(n_dhi - b_dhi > 0), 1);
    hold(1'b0, 510);
    chk("w2_data",  32'(rgb_data),          32'h123456);
    chk("w2_xfer",  32'(n_xfer - b_xfer),   1);
    chk("w2_latch", 32'(n_latch - b_latch), 1);
    chk("w2_valid", 32'(rgb_valid),         0);

    // Partial word of 12 bits then gap
    rdy = 1'b0;
    snap();
    send_bits(24'hA5A5A5, 12);
    hold(1'b0, 510);
    chk("part_ferr",  32'(n_ferr - b_ferr),   1);
    chk("part_latch", 32'(n_latch - b_latch), 0);
    chk("part_valid", 32'(rgb_valid),         0);

    // Backpressure: second frame's word is dropped
    snap();
    send_bits(24'h000001, 24);
    hold(1'b0, 510);
    send_bits(24'h000002, 24);
    hold(1'b0, 510);
    chk("ovr_data",  32'(rgb_data),          32'h000001);
    chk("ovr_valid", 32'(rgb_valid),         1);
    chk("ovr_flag",  32'(overrun),           1);
    chk("ovr_latch", 32'(n_latch - b_latch), 2);
    rdy = 1'b1;
    hold(1'b0, 1);
    rdy = 1'b0;
    chk("ovr_consumed", 32'(rgb_valid), 0);
    chk("ovr_sticky",   32'(overrun),   1);

    // Over-long high pulse mid-word
    snap();
    send_bits(24'hF0F0F0, 5);
    hold(1'b1, 20);
    chk("long_ferr",  32'(n_ferr - b_ferr),  1);
    chk("long_state", 32'(dut.state_q),      32'(SYNC));
    hold(1'b0, 20);
    send_bits(24'h0F0F0F, 24);
    hold(1'b0, 510);
    chk("long_ignored_valid", 32'(rgb_valid),         0);
    chk("long_ignored_latch", 32'(n_latch - b_latch), 0);
    send_bits(24'h0F0F0F, 24);
    hold(1'b0, 510);
    chk("long_next_data",  32'(rgb_data),          32'h0F0F0F);
    chk("long_next_valid", 32'(rgb_valid),         1);
    chk("long_next_latch", 32'(n_latch - b_latch), 1);

    // Reset after 10 bits, then a clean frame
    send_bits(24'h5A5A5A, 10);
    rst = 1'b1;
    hold(1'b0, 2);
    chk_reset_outs("mid_rst");
    rst = 1'b0;
    hold(1'b0, 510);
    snap();
    send_bits(24'hC3A55A, 24);
    hold(1'b0, 510);
    chk("post_rst_data",  32'(rgb_data),          32'hC3A55A);
    chk("post_rst_valid", 32'(rgb_valid),         1);
    chk("post_rst_latch", 32'(n_latch - b_latch), 1);
    chk("post_rst_ferr",  32'(n_ferr - b_ferr),   0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
